// File: rtl/rv_mem_arb.sv
// Shares one single-port memory bus between the core's fetch and data ports, one step at a time.
// Optional single-entry fetch buffer: define RV_ARB_IBUF_EN.
module rv_mem_arb #(
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned DFIRST   = 1
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [31:0] i_adr,
  input  logic        i_re,
  output logic [31:0] i_dr,
  output logic        i_rdy,
  input  logic [31:0] d_adr,
  input  logic        d_re,
  input  logic [31:0] d_dw,
  input  logic [3:0]  d_we,
  output logic [31:0] d_dr,
  output logic        d_rdy,
  output logic [31:0] m_adr,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [31:0] m_dw,
  input  logic [31:0] m_dr,
  input  logic        m_ack,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a core step
  // D_ACC | data access on the bus
  // I_ACC | instruction fetch on the bus
  // DONE  | core released for one cycle
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t      state_q, state_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [31:0] ibuf_q, ibuf_d, dbuf_q, dbuf_d;
  logic [31:0] i_dr_q, i_dr_d, d_dr_q, d_dr_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic        i_done_q, i_done_d, d_done_q, d_done_d;
  logic        dreq, ihit, ipend, dpend, acc, tmo, fin;
  logic [31:0] rdata;

`ifdef RV_ARB_IBUF_EN
  logic [31:0] tag_q, tag_d;
  logic        ival_q, ival_d;
  logic        st_inval;
  assign st_inval = (state_q == D_ACC) && (d_we != 4'b0) && (d_adr[31:2] == tag_q[31:2]);
  assign ihit     = ival_q && (i_adr == tag_q) && !st_inval;
`else
  assign ihit = 1'b0;
`endif

  assign dreq  = d_re | (d_we != 4'b0);
  assign ipend = i_re & ~i_done_q & ~ihit;
  assign dpend = dreq & ~d_done_q;
  assign acc   = (state_q == D_ACC) || (state_q == I_ACC);
  // An ack in the final wait cycle beats the timeout.
  assign tmo   = acc && !m_ack && (wcnt_q == WAIT_LAST);
  assign fin   = acc && (m_ack || tmo);
  assign rdata = m_ack ? m_dr : 32'h0;

  always_comb begin
    state_d  = state_q;
    ibuf_d   = ibuf_q;
    dbuf_d   = dbuf_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
    m_adr    = 32'h0;
    m_re     = 1'b0;
    m_we     = 4'b0;
    m_dw     = 32'h0;
`ifdef RV_ARB_IBUF_EN
    tag_d    = tag_q;
    ival_d   = ival_q;
`endif
    unique case (state_q)
      IDLE: begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        if (dreq || i_re) dbuf_d = 32'h0;
        if (DFIRST != 0) begin
          if (dreq)       state_d = D_ACC;
          else if (ipend) state_d = I_ACC;
          else if (i_re)  state_d = DONE;
        end else begin
          if (ipend)      state_d = I_ACC;
          else if (dreq)  state_d = D_ACC;
          else if (i_re)  state_d = DONE;
        end
      end
      D_ACC: begin
        m_adr = d_adr;
        m_re  = d_re;
        m_we  = d_we;
        m_dw  = d_dw;
        if (fin) begin
          dbuf_d   = d_re ? rdata : 32'h0;
          d_done_d = 1'b1;
          state_d  = ipend ? I_ACC : DONE;
        end
      end
      I_ACC: begin
        m_adr = i_adr;
        m_re  = 1'b1;
        if (fin) begin
          ibuf_d   = rdata;
          i_done_d = 1'b1;
          state_d  = dpend ? D_ACC : DONE;
`ifdef RV_ARB_IBUF_EN
          tag_d    = i_adr;
          ival_d   = m_ack;
`endif
        end
      end
      DONE: begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef RV_ARB_IBUF_EN
    if (st_inval) ival_d = 1'b0;
`endif
  end

  always_comb begin
    wcnt_d = (acc && !fin) ? wcnt_q + 16'd1 : 16'd0;
    err_d  = err_q | tmo;
    rdy_d  = (state_d == DONE);
    i_dr_d = rdy_d ? ibuf_d : i_dr_q;
    d_dr_d = rdy_d ? dbuf_d : d_dr_q;
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_q  <= IDLE;
      wcnt_q   <= 16'd0;
      ibuf_q   <= 32'h0;
      dbuf_q   <= 32'h0;
      i_dr_q   <= 32'h0;
      d_dr_q   <= 32'h0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ibuf_q   <= ibuf_d;
      dbuf_q   <= dbuf_d;
      i_dr_q   <= i_dr_d;
      d_dr_q   <= d_dr_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
    end
  end

`ifdef RV_ARB_IBUF_EN
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      tag_q  <= 32'h0;
      ival_q <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      ival_q <= ival_d;
    end
  end
`endif

  assign i_rdy = rdy_q;
  assign d_rdy = rdy_q;
  assign i_dr  = i_dr_q;
  assign d_dr  = d_dr_q;
  assign err   = err_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb (WAIT_MAX=4, DFIRST=1) with a small ack-delay memory responder.
module tb_rv_mem_arb;

  logic        clk = 1'b0;
  logic        xreset;
  logic [31:0] i_adr, d_adr, d_dw, m_adr, m_dw, m_dr, i_dr, d_dr;
  logic        i_re, d_re, i_rdy, d_rdy, m_re, m_ack, err;
  logic [3:0]  d_we, m_we;

  logic        ack_en = 1'b1;
  logic        force_ack = 1'b0;
  int          ack_delay = 0;
  int          age = 0;
  int          re_cycles = 0;
  logic [31:0] adr_q[$];

  int nvec = 0;
  int nbad = 0;

  rv_mem_arb #(.WAIT_MAX(4), .DFIRST(1)) dut (
    .clk(clk), .xreset(xreset),
    .i_adr(i_adr), .i_re(i_re), .i_dr(i_dr), .i_rdy(i_rdy),
    .d_adr(d_adr), .d_re(d_re), .d_dw(d_dw), .d_we(d_we), .d_dr(d_dr), .d_rdy(d_rdy),
    .m_adr(m_adr), .m_re(m_re), .m_we(m_we), .m_dw(m_dw), .m_dr(m_dr), .m_ack(m_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_rd = 32'h0000_0013;
      32'h0000_0104: mem_rd = 32'h0010_0093;
      32'h0000_2000: mem_rd = 32'hCAFE_F00D;
      default:       mem_rd = {16'hDEAD, a[15:0]};
    endcase
  endfunction

  always_comb begin
    m_ack = force_ack | (ack_en & (m_re | (m_we != 4'b0)) & (age >= ack_delay));
    m_dr  = m_ack ? mem_rd(m_adr) : 32'h5555_5555;
  end

  always @(posedge clk) begin
    if (m_re) re_cycles <= re_cycles + 1;
    if (m_ack && (m_re || m_we != 4'b0)) begin
      adr_q.push_back(m_adr);
      age <= 0;
    end else if (m_re || m_we != 4'b0) begin
      age <= age + 1;
    end else begin
      age <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Applies one core step, waits for the release cycle, checks latency and returned words.
  task automatic step(input string tag, input logic [31:0] ia, input logic ire,
                      input logic [31:0] da, input logic dre, input logic [3:0] dwe,
                      input logic [31:0] ddw, input int ek,
                      input logic [31:0] ei, input logic [31:0] ed);
    int k = 0;
    @(negedge clk);
    i_adr = ia; i_re = ire; d_adr = da; d_re = dre; d_we = dwe; d_dw = ddw;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      @(negedge clk);
      if (i_rdy) k = n;
      else begin
        chk({tag, " d_rdy busy"}, {31'b0, d_rdy}, 32'h0);
        if (m_we != 4'b0) begin
          chk({tag, " m_we stable"}, {28'b0, m_we}, {28'b0, dwe});
          chk({tag, " m_dw stable"}, m_dw, ddw);
        end
      end
    end
    if (k == 0) chk({tag, " done seen"}, 32'h0, 32'h1);
    else begin
      chk({tag, " latency"}, k, ek);
      chk({tag, " d_rdy"}, {31'b0, d_rdy}, 32'h1);
      chk({tag, " i_dr"}, i_dr, ei);
      chk({tag, " d_dr"}, d_dr, ed);
    end
    i_re = 1'b0; d_re = 1'b0; d_we = 4'b0;
    @(negedge clk);
    chk({tag, " rdy one cycle"}, {30'b0, i_rdy, d_rdy}, 32'h0);
  endtask

  initial begin
    int r0;
    xreset = 1'b0;
    i_adr = 32'h0; i_re = 1'b0; d_adr = 32'h0; d_re = 1'b0; d_we = 4'b0; d_dw = 32'h0;
    #3;
    chk("rst rdy", {30'b0, i_rdy, d_rdy}, 32'h0);
    chk("rst i_dr", i_dr, 32'h0);
    chk("rst d_dr", d_dr, 32'h0);
    chk("rst bus", {m_adr[27:0], m_re, m_we[2:0]}, 32'h0);
    chk("rst err", {31'b0, err}, 32'h0);
    @(negedge clk);
    xreset = 1'b1;

    // fetch-only, zero wait
    adr_q.delete(); r0 = re_cycles;
    step("fetch", 32'h100, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 2, 32'h0000_0013, 32'h0);
    chk("fetch m_re cycles", re_cycles - r0, 1);
    chk("fetch bus adr", (adr_q.size() == 1) ? adr_q[0] : 32'hFFFF_FFFF, 32'h100);

    // load then fetch
    adr_q.delete();
    step("ldfetch", 32'h104, 1'b1, 32'h2000, 1'b1, 4'h0, 32'h0, 3, 32'h0010_0093, 32'hCAFE_F00D);
    chk("ldfetch n acc", adr_q.size(), 2);
    if (adr_q.size() == 2) begin
      chk("ldfetch first", adr_q[0], 32'h2000);
      chk("ldfetch second", adr_q[1], 32'h104);
    end
    @(negedge clk);
    chk("hold i_dr", i_dr, 32'h0010_0093);
    chk("hold d_dr", d_dr, 32'hCAFE_F00D);

    // store, ack 3 cycles late (ack coincides with last wait cycle: ack wins)
    ack_delay = 3;
    step("store", 32'h0, 1'b0, 32'h3000, 1'b0, 4'b0011, 32'h0000_BEEF, 5, 32'h0010_0093, 32'h0);
    chk("store err", {31'b0, err}, 32'h0);

    // timeout
    ack_delay = 0; ack_en = 1'b0;
    step("tmo", 32'h300, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 5, 32'h0, 32'h0);
    chk("tmo err", {31'b0, err}, 32'h1);
    ack_en = 1'b1;
    step("after tmo", 32'h100, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 2, 32'h0000_0013, 32'h0);
    chk("err sticky", {31'b0, err}, 32'h1);

    // reset in the middle of a data access, then a stray ack
    ack_en = 1'b0;
    @(negedge clk);
    i_adr = 32'h104; i_re = 1'b1; d_adr = 32'h2000; d_re = 1'b1;
    @(negedge clk);
    chk("mid m_re", {31'b0, m_re}, 32'h1);
    chk("mid m_adr", m_adr, 32'h2000);
    #2 xreset = 1'b0;
    #1;
    chk("rst bus", {m_adr[27:0], m_re, m_we[2:0]}, 32'h0);
    chk("rst outs", {i_rdy, d_rdy, err, 29'b0}, 32'h0);
    chk("rst i_dr2", i_dr, 32'h0);
    chk("rst d_dr2", d_dr, 32'h0);
    @(negedge clk);
    xreset = 1'b1; i_re = 1'b0; d_re = 1'b0; force_ack = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stray ack", {29'b0, i_rdy, m_re, err}, 32'h0);
    end
    force_ack = 1'b0; ack_en = 1'b1;

`ifdef RV_ARB_IBUF_EN
    step("ib miss", 32'h200, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 2, 32'hDEAD_0200, 32'h0);
    r0 = re_cycles;
    step("ib hit", 32'h200, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 1, 32'hDEAD_0200, 32'h0);
    chk("ib hit no bus", re_cycles - r0, 0);
    step("ib store", 32'h0, 1'b0, 32'h200, 1'b0, 4'hF, 32'h1234, 2, 32'hDEAD_0200, 32'h0);
    r0 = re_cycles;
    step("ib refetch", 32'h200, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 2, 32'hDEAD_0200, 32'h0);
    chk("ib refetch bus", re_cycles - r0, 1);
`else
    r0 = re_cycles;
    step("refetch", 32'h100, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 2, 32'h0000_0013, 32'h0);
    chk("refetch bus", re_cycles - r0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Sequencer that time-multiplexes the core's instruction port and data port onto one shared single-port memory bus with an ack handshake.
- Sits between rv_core and a unified RAM or peripheral bus.
- Holds i_rdy/d_rdy low until both accesses of the current core step have finished, then releases the core for one cycle with latched read data.

Parameters:
- WAIT_MAX, 255: maximum cycles spent waiting for m_ack before an access is forced complete (range 1..65535).
- DFIRST, 1: access order within a step; 1 = data access then fetch, 0 = fetch then data access.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- xreset  in  1  asynchronous, active-low reset.
- i_adr  in  32  instruction fetch address from core.
- i_re  in  1  fetch request.
- i_dr  out  32  fetched instruction word.
- i_rdy  out  1  fetch complete / core may advance.
- d_adr  in  32  data address.
- d_re  in  1  data read enable.
- d_dw  in  32  data write data, already lane-aligned.
- d_we  in  4  byte write enables.
- d_dr  out  32  data read word.
- d_rdy  out  1  data access complete.
- m_adr  out  32  shared bus address.
- m_re  out  1  shared bus read request.
- m_we  out  4  shared bus byte write enables.
- m_dw  out  32  shared bus write data.
- m_dr  in  32  shared bus read data, valid while m_ack=1.
- m_ack  in  1  access done; may assert in the same cycle as the request.
- err  out  1  sticky bus-timeout flag.

Behaviour:
- Core contract: the core holds i_adr, d_adr, d_re, d_we and d_dw stable while i_rdy & d_rdy = 0.
- Reset state (async, xreset=0): state=IDLE; i_rdy=0, d_rdy=0, i_dr=0, d_dr=0, m_re=0, m_we=0, m_adr=0, m_dw=0, err=0; buffers and wait counter cleared. Any access in flight is abandoned immediately. An m_ack arriving after reset release while in IDLE is ignored.
- States: IDLE, D_ACC, I_ACC, DONE.
- IDLE transition (DFIRST=1):
  - dreq = d_re | (d_we != 0).
  - dreq=1: go to D_ACC.
  - else i_re=1: go to I_ACC.
  - else stay in IDLE.
- IDLE transition (DFIRST=0): I_ACC has priority, then D_ACC.
- D_ACC bus drive: m_adr=d_adr, m_re=d_re, m_we=d_we, m_dw=d_dw, all combinational from state and inputs.
- D_ACC completion on m_ack:
  - dbuf <= d_re ? m_dr : 0.
  - Go to I_ACC if the fetch is still pending, else DONE.
- I_ACC bus drive: m_adr=i_adr, m_re=1, m_we=0, m_dw=0.
- I_ACC completion on m_ack: ibuf <= m_dr; go to D_ACC if dreq is still pending, else DONE.
- DONE: i_rdy=d_rdy=1 for exactly one cycle, i_dr=ibuf, d_dr=dbuf; then go to IDLE. In every other state i_rdy=d_rdy=0 and i_dr/d_dr hold their last values.
- A step with no data access gives d_dr=0. This keeps the core's OR-merge with its internal mtime read path correct.
- Outside D_ACC and I_ACC: m_re=0, m_we=0.
- Latency: minimum 4 cycles per step with both accesses and zero-wait ack; 3 cycles for fetch-only.
- Wait counter (16 bit):
  - Cleared on entry to D_ACC or I_ACC and on every ack.
  - Increments each cycle the current access waits without ack.
  - Reaching WAIT_MAX: the access completes as if acked with read data 0, and err <= 1.
  - err clears only by reset.
- m_ack outside D_ACC and I_ACC is ignored.
- Simultaneous ack and timeout in the same cycle: the ack wins; data = m_dr and err is unchanged.

Optional Feature:
- Macro RV_ARB_IBUF_EN.
- With the macro: a single-entry fetch buffer, made of tag = last fetched i_adr, a valid bit, and ibuf.
  - In IDLE/D_ACC, if i_adr == tag and valid, I_ACC is skipped; a fetch-only hit goes IDLE -> DONE in 2 cycles.
  - A D_ACC with any d_we bit set and d_adr[31:2] == tag[31:2] clears valid.
  - Reset clears valid.
- Without the macro: every step performs I_ACC.

Test Plan:
- Zero-wait fetch-only step, i_adr=0x100, m_dr=0x00000013 with ack on request: m_re high one cycle with m_adr=0x100; i_rdy=d_rdy=1 in the third cycle with i_dr=0x00000013 and d_dr=0.
- Load plus fetch, DFIRST=1, d_adr=0x2000, d_re=1, i_adr=0x104: bus order is 0x2000 then 0x104. DONE gives d_dr = data word and i_dr = insn word, 4 cycles total.
- Store with 3-cycle ack delay, d_we=4'b0011, d_dw=0x0000BEEF: m_we and m_dw stay stable until ack; d_rdy is low throughout; d_dr=0 in DONE.
- Timeout, WAIT_MAX=4, m_ack tied 0: after 4 wait cycles the access completes with data 0 and err=1; err stays 1 until xreset pulses low.
- xreset asserted mid-D_ACC, then an ack after release: outputs are zero immediately, state is IDLE, and the stray ack is ignored.
- RV_ARB_IBUF_EN: repeated fetch of 0x200 completes in 2 cycles with no bus access. A store to 0x200 forces a refetch on the next step.
